// File: rtl/berzerk_nvram_io_if.sv
// hps_io ioctl channel as seen by the Berzerk NVRAM bridge.
// The master is the HPS side and the slave is the bridge.
interface berzerk_nvram_io_if;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_wr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_download, ioctl_upload, ioctl_index,
        output ioctl_addr, ioctl_wr, ioctl_rd, ioctl_dout,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_download, ioctl_upload, ioctl_index,
        input  ioctl_addr, ioctl_wr, ioctl_rd, ioctl_dout,
        output ioctl_din, ioctl_wait
    );
endinterface

// File: rtl/berzerk_nvram_io.sv
// ioctl <-> Berzerk CMOS RAM bridge, stalls HPS while the CPU owns the RAM.
// Define NVRAM_DIRTY_EN to build the autosave dirty flag (else tied to 0).
module berzerk_nvram_io #(
    parameter int         AW       = 10,
    parameter logic [7:0] NV_INDEX = 8'd4
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    berzerk_nvram_io_if.slave   io,
    input  logic                cpu_busy,
    input  logic                cpu_nv_wr,
    output logic [AW-1:0]       nv_addr,
    output logic                nv_we,
    output logic [7:0]          nv_wdata,
    input  logic [7:0]          nv_rdata,
    output logic                nv_dirty
);

    typedef enum logic [2:0] {
        IDLE, WAIT_SLOT, READ, LATCH, WRITE
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [7:0]    data_q;
    logic          wr_q;
    logic          up_q;
    logic          sel;
    logic          in_range;
    logic          last_up;

    assign sel      = (io.ioctl_index == NV_INDEX) &&
                      (io.ioctl_download || io.ioctl_upload);
    assign in_range = (io.ioctl_addr[24:AW] == '0);
    assign last_up  = (state == LATCH) && up_q && (&addr_q);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            wr_q          <= 1'b0;
            up_q          <= 1'b0;
            nv_addr       <= '0;
            nv_wdata      <= '0;
            nv_we         <= 1'b0;
            io.ioctl_din  <= '0;
            io.ioctl_wait <= 1'b0;
        end else begin
            nv_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    // write has priority; a read in the same cycle is dropped
                    if (sel && io.ioctl_wr) begin
                        if (in_range) begin
                            addr_q        <= io.ioctl_addr[AW-1:0];
                            data_q        <= io.ioctl_dout;
                            wr_q          <= 1'b1;
                            up_q          <= io.ioctl_upload;
                            io.ioctl_wait <= 1'b1;
                            state         <= WAIT_SLOT;
                        end
                    end else if (sel && io.ioctl_rd) begin
                        if (in_range) begin
                            addr_q        <= io.ioctl_addr[AW-1:0];
                            wr_q          <= 1'b0;
                            up_q          <= io.ioctl_upload;
                            io.ioctl_wait <= 1'b1;
                            state         <= WAIT_SLOT;
                        end else begin
                            io.ioctl_din  <= 8'h00;
                        end
                    end
                end
                WAIT_SLOT: begin
                    if (!cpu_busy) begin
                        nv_addr <= addr_q;
                        if (wr_q) begin
                            nv_wdata <= data_q;
                            nv_we    <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            state    <= READ;
                        end
                    end
                end
                READ: state <= LATCH;
                LATCH: begin
                    io.ioctl_din  <= nv_rdata;
                    io.ioctl_wait <= 1'b0;
                    state         <= IDLE;
                end
                WRITE: begin
                    io.ioctl_wait <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NVRAM_DIRTY_EN
    // a CPU write in the same cycle as the final upload latch keeps it dirty
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            nv_dirty <= 1'b0;
        else if (cpu_nv_wr)
            nv_dirty <= 1'b1;
        else if (last_up)
            nv_dirty <= 1'b0;
    end
`else
    logic unused;
    assign nv_dirty = 1'b0;
    assign unused   = &{1'b0, cpu_nv_wr, last_up};
`endif

endmodule

// File: tb/tb_berzerk_nvram_io.sv
// Scoreboard bench for berzerk_nvram_io with a behavioural 1 KB RAM.
// Dirty expectations follow NVRAM_DIRTY_EN.
module tb_berzerk_nvram_io;

`ifdef NVRAM_DIRTY_EN
    localparam logic DEN = 1'b1;
`else
    localparam logic DEN = 1'b0;
`endif

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic       rd;
        logic [7:0] d;
    } op_t;

    logic       clk;
    logic       rst_n;
    logic       cpu_busy;
    logic       cpu_nv_wr;
    logic [9:0] nv_addr;
    logic       nv_we;
    logic [7:0] nv_wdata;
    logic [7:0] nv_rdata;
    logic       nv_dirty;
    logic [7:0] mem [1024];
    logic       prev_wait;

    int  n_chk  = 0;
    int  n_fail = 0;
    wr_t exp_wr[$];
    op_t ops[$];

    berzerk_nvram_io_if io();

    berzerk_nvram_io #(.AW(10), .NV_INDEX(8'd4)) dut (
        .clk_sys   (clk),
        .reset_n   (rst_n),
        .io        (io),
        .cpu_busy  (cpu_busy),
        .cpu_nv_wr (cpu_nv_wr),
        .nv_addr   (nv_addr),
        .nv_we     (nv_we),
        .nv_wdata  (nv_wdata),
        .nv_rdata  (nv_rdata),
        .nv_dirty  (nv_dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (nv_we) mem[nv_addr] <= nv_wdata;
        nv_rdata <= mem[nv_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && nv_we) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_we", 32'(nv_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("we_addr", 32'(nv_addr), 32'(w.a));
                chk("we_data", 32'(nv_wdata), 32'(w.d));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && !io.ioctl_wait) begin
                if (ops.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    op_t o;
                    o = ops.pop_front();
                    if (o.rd) chk("rd_data", 32'(io.ioctl_din), 32'(o.d));
                end
            end
            prev_wait = io.ioctl_wait;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic rd,
                         input logic [24:0] a, input logic [7:0] d,
                         input logic [7:0] idx, input logic up);
        cyc();
        io.ioctl_index    = idx;
        io.ioctl_upload   = up;
        io.ioctl_download = !up;
        io.ioctl_addr     = a;
        io.ioctl_dout     = d;
        io.ioctl_wr       = wr;
        io.ioctl_rd       = rd;
        cyc();
        io.ioctl_wr = 1'b0;
        io.ioctl_rd = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!io.ioctl_wait) return;
            cyc();
        end
        chk("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        wr_t w;
        op_t o;
        w.a = a; w.d = d;
        o.rd = 1'b0; o.d = 8'h00;
        exp_wr.push_back(w);
        ops.push_back(o);
        issue(1'b1, 1'b0, 25'(a), d, 8'd4, 1'b0);
        wait_idle();
    endtask

    task automatic do_read(input logic [9:0] a, input logic [7:0] d);
        op_t o;
        o.rd = 1'b1; o.d = d;
        ops.push_back(o);
        issue(1'b0, 1'b1, 25'(a), 8'h00, 8'd4, 1'b1);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        op_t o;
        wr_t w;
        logic [7:0] din_prev;

        rst_n = 1'b0;
        cpu_busy = 1'b0;
        cpu_nv_wr = 1'b0;
        io.ioctl_download = 1'b0;
        io.ioctl_upload   = 1'b0;
        io.ioctl_index    = 8'd0;
        io.ioctl_addr     = '0;
        io.ioctl_wr       = 1'b0;
        io.ioctl_rd       = 1'b0;
        io.ioctl_dout     = 8'h00;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_din",   32'(io.ioctl_din), 32'h0);
        chk("rst_wait",  32'(io.ioctl_wait), 32'h0);
        chk("rst_we",    32'(nv_we), 32'h0);
        chk("rst_addr",  32'(nv_addr), 32'h0);
        chk("rst_wdata", 32'(nv_wdata), 32'h0);
        chk("rst_dirty", 32'(nv_dirty), 32'h0);

        // download write 0x123 = A5 with exact cycle timing
        w.a = 10'h123; w.d = 8'hA5;
        o.rd = 1'b0; o.d = 8'h00;
        exp_wr.push_back(w);
        ops.push_back(o);
        issue(1'b1, 1'b0, 25'h123, 8'hA5, 8'd4, 1'b0);
        chk("wr_c1_wait", 32'(io.ioctl_wait), 32'h1);
        chk("wr_c1_we",   32'(nv_we), 32'h0);
        cyc();
        chk("wr_c2_we",   32'(nv_we), 32'h1);
        chk("wr_c2_addr", 32'(nv_addr), 32'h123);
        chk("wr_c2_data", 32'(nv_wdata), 32'hA5);
        chk("wr_c2_wait", 32'(io.ioctl_wait), 32'h1);
        cyc();
        chk("wr_c3_wait", 32'(io.ioctl_wait), 32'h0);
        chk("wr_c3_we",   32'(nv_we), 32'h0);

        do_write(10'h3FF, 8'h5A);
        chk("dl_dirty", 32'(nv_dirty), 32'h0);

        cpu_nv_wr = 1'b1;
        cyc();
        cpu_nv_wr = 1'b0;
        chk("cpu_set_dirty", 32'(nv_dirty), 32'(DEN));

        // upload read of last byte with 3 busy cycles
        o.rd = 1'b1; o.d = 8'h5A;
        ops.push_back(o);
        issue(1'b0, 1'b1, 25'h3FF, 8'h00, 8'd4, 1'b1);
        cpu_busy = 1'b1;
        cyc();
        cyc();
        cyc();
        cpu_busy = 1'b0;
        chk("busy_c4_wait", 32'(io.ioctl_wait), 32'h1);
        cyc();
        cyc();
        chk("busy_c6_wait", 32'(io.ioctl_wait), 32'h1);
        cyc();
        chk("busy_c7_wait", 32'(io.ioctl_wait), 32'h0);
        chk("busy_c7_din",  32'(io.ioctl_din), 32'h5A);
        chk("upload_clear", 32'(nv_dirty), 32'h0);

        // CPU write coincides with the final-address latch
        o.rd = 1'b1; o.d = 8'h5A;
        ops.push_back(o);
        issue(1'b0, 1'b1, 25'h3FF, 8'h00, 8'd4, 1'b1);
        cyc();
        cyc();
        cpu_nv_wr = 1'b1;
        cyc();
        cpu_nv_wr = 1'b0;
        chk("prio_wait",  32'(io.ioctl_wait), 32'h0);
        chk("prio_dirty", 32'(nv_dirty), 32'(DEN));

        issue(1'b0, 1'b1, 25'h400, 8'h00, 8'd4, 1'b1);
        chk("oor_rd_din",  32'(io.ioctl_din), 32'h00);
        chk("oor_rd_wait", 32'(io.ioctl_wait), 32'h0);
        cyc();
        chk("oor_rd_wait2", 32'(io.ioctl_wait), 32'h0);

        issue(1'b1, 1'b0, 25'h400, 8'hEE, 8'd4, 1'b0);
        chk("oor_wr_wait", 32'(io.ioctl_wait), 32'h0);
        repeat (3) cyc();
        chk("oor_wr_we", 32'(nv_we), 32'h0);

        // reset while the write sits in WAIT_SLOT
        issue(1'b1, 1'b0, 25'h050, 8'h77, 8'd4, 1'b0);
        cpu_busy = 1'b1;
        cyc();
        chk("mid_wait_hi", 32'(io.ioctl_wait), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wait", 32'(io.ioctl_wait), 32'h0);
        chk("mid_rst_we",   32'(nv_we), 32'h0);
        cyc();
        cpu_busy = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("mid_rst_idle", 32'(io.ioctl_wait), 32'h0);
        chk("mid_rst_dirty", 32'(nv_dirty), 32'h0);
        do_read(10'h050, 8'h00);

        // simultaneous rd+wr: only the write happens, din untouched
        din_prev = io.ioctl_din;
        w.a = 10'h200; w.d = 8'h3C;
        o.rd = 1'b0; o.d = 8'h00;
        exp_wr.push_back(w);
        ops.push_back(o);
        issue(1'b1, 1'b1, 25'h200, 8'h3C, 8'd4, 1'b0);
        wait_idle();
        cyc();
        chk("rdwr_din_hold", 32'(io.ioctl_din), 32'(din_prev));
        do_read(10'h200, 8'h3C);

        issue(1'b1, 1'b0, 25'h010, 8'h99, 8'd3, 1'b0);
        chk("idx3_wr_wait", 32'(io.ioctl_wait), 32'h0);
        cyc();
        chk("idx3_wr_we", 32'(nv_we), 32'h0);
        din_prev = io.ioctl_din;
        issue(1'b0, 1'b1, 25'h123, 8'h00, 8'd3, 1'b1);
        chk("idx3_rd_wait", 32'(io.ioctl_wait), 32'h0);
        cyc();
        chk("idx3_rd_din", 32'(io.ioctl_din), 32'(din_prev));
        do_read(10'h010, 8'h00);

        do_read(10'h123, 8'hA5);
        do_write(10'h001, 8'h11);
        do_read(10'h001, 8'h11);

        repeat (3) cyc();
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("op_queue_empty", 32'(ops.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/berzerk_nvram_io.md
# berzerk_nvram_io

Bridge between the `hps_io` ioctl channel and the Berzerk core's 1 KB battery-backed CMOS RAM. It services index-4 downloads (HPS→RAM, restoring saved high scores) and index-4 uploads (RAM→HPS, saving them), stalling the HPS with `ioctl_wait` while the CPU owns the RAM. It sits in `emu` between `hps_io` and the NVRAM port exposed by `berzerk`, and provides a dirty flag for autosave.

## Interface
- `AW`, 10: NVRAM address width; depth = 2^AW bytes.
- `NV_INDEX`, 4: ioctl index that selects NVRAM transfers.
- `clk_sys` in 1: system clock, 40 MHz; sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: HPS download active.
- `ioctl_upload` in 1: HPS upload active.
- `ioctl_index` in 8: transfer index.
- `ioctl_addr` in 25: byte address.
- `ioctl_wr` in 1: one-cycle write strobe.
- `ioctl_rd` in 1: one-cycle read strobe.
- `ioctl_dout` in 8: write data from the HPS.
- `ioctl_din` out 8: read data to the HPS; registered.
- `ioctl_wait` out 1: HPS stall; registered.
- `cpu_busy` in 1: the CPU owns the RAM port this cycle.
- `cpu_nv_wr` in 1: the CPU wrote NVRAM this cycle; sets dirty.
- `nv_addr` out AW: RAM address.
- `nv_we` out 1: RAM write enable, one cycle.
- `nv_wdata` out 8: RAM write data.
- `nv_rdata` in 8: RAM read data, one-cycle latency.
- `nv_dirty` out 1: NVRAM changed since the last complete upload.

## Operation
- A transfer is selected when `ioctl_index == NV_INDEX` and either `ioctl_download` or `ioctl_upload` is high. Strobes arriving without a selected transfer are ignored.
- FSM states: IDLE, WAIT_SLOT, READ, LATCH, WRITE.
- IDLE:
  - On a selected strobe, latch the address and data, assert wait, and go to WAIT_SLOT.
  - If `ioctl_wr` and `ioctl_rd` arrive together, the write wins and the read is dropped.
- WAIT_SLOT:
  - Stay while `cpu_busy` is high. There is no timeout; the CPU always has priority.
  - When `cpu_busy` is low, go to WRITE (write op) or READ (read op).
- WRITE: drive `nv_addr`, `nv_wdata`, `nv_we=1` for one cycle, then go to IDLE.
- READ: drive `nv_addr`, then go to LATCH.
- LATCH: `ioctl_din <= nv_rdata`, then go to IDLE.
- `ioctl_wait` is high in every state except IDLE.
- `nv_addr`, `nv_wdata` and `nv_we` are driven only in READ/WRITE. `nv_we` is 0 in all other states.
- Out-of-range addresses (`ioctl_addr >= 2^AW`):
  - Write: ignored; no FSM entry, no wait.
  - Read: `ioctl_din <= 8'h00` in the same cycle; no wait.
- Address arithmetic: `nv_addr = ioctl_addr[AW-1:0]`, captured at the strobe.
- Dirty tracking:
  - `cpu_nv_wr` sets dirty.
  - Completing the LATCH of address 2^AW-1 during an upload clears dirty.
  - If a set and a clear occur in the same cycle, set wins.
  - Downloads do not change dirty.

## Timing
- Reset values: `ioctl_din=0`, `ioctl_wait=0`, `nv_we=0`, `nv_addr=0`, `nv_wdata=0`, `nv_dirty=0`, FSM=IDLE.
- `reset_n` low mid-transfer aborts the FSM immediately (asynchronous). Any pending write is not performed.
- Read with `cpu_busy` low, strobe sampled in cycle 0:
  - Cycle 1: WAIT_SLOT, wait=1.
  - Cycle 2: READ, `nv_addr` valid.
  - Cycle 3: LATCH, `nv_rdata` valid.
  - Cycle 4: IDLE, wait=0, `ioctl_din` valid.
  - Read latency is 4 cycles.
- Write with `cpu_busy` low, strobe in cycle 0:
  - Cycle 2: WRITE, `nv_we=1`.
  - Cycle 3: IDLE, wait=0.
- Each cycle `cpu_busy` is high in WAIT_SLOT adds exactly one cycle of latency.
- `ioctl_din` holds its value until the next read completes.
- Strobes arriving while wait=1 violate the protocol and are ignored.

## Configuration
- `NVRAM_DIRTY_EN` defined: the dirty flag logic is compiled in as described above.
- `NVRAM_DIRTY_EN` undefined: `nv_dirty` is tied to 0, and `cpu_nv_wr` is unused. All transfer behaviour is identical.

## Test plan
- Reset: hold `reset_n=0`, then release → all outputs 0, FSM IDLE, no `nv_we`.
- Download write: index 4, `ioctl_wr` at addr 0x123 with data 0xA5, `cpu_busy=0` → `nv_we` high exactly in cycle 2 with `nv_addr=0x123` and `nv_wdata=0xA5`; wait high in cycles 1–2 only.
- Upload read under contention: RAM[0x3FF]=0x5A, `cpu_busy` high for 3 cycles after the strobe → wait low in cycle 7, `ioctl_din=0x5A`, `nv_dirty` cleared.
- Out-of-range: read at 0x400 → `ioctl_din=0x00`, wait never asserted. Write at 0x400 → no `nv_we`.
- Dirty priority: `cpu_nv_wr=1` in the same cycle as the final-address LATCH → `nv_dirty` stays 1. With `NVRAM_DIRTY_EN` undefined → `nv_dirty` stays 0 throughout.
- Mid-transfer reset and ignored strobes:
  - Pull `reset_n` low during WAIT_SLOT of a write → no `nv_we`; wait=0 immediately.
  - Simultaneous rd+wr → only the write is performed.
  - Wrong index (3) → strobes ignored.
